// File: rtl/fpu_seq_unit.sv
// Purpose : sequential single-precision FPU serving the MemArbiter FPU port
//           (LDA/LDB/MUL/MIN/MAX/NEG/ABS on two operand registers A and B).
// Latency : single-cycle ops -> done in t+1; MUL -> busy t+1..t+26, done t+27.
// Backpressure: none; any command sampled while io_busy is high is dropped.
//
// Ports:
//   clock, reset       sole clock (rising edge), synchronous active-high reset
//   io_fpu_op   [2:0]  command: 0 NOP, 1 LDA, 2 LDB, 3 MUL, 4 MIN, 5 MAX, 6 NEG, 7 ABS
//   io_fpu_ab   [31:0] operand data for LDA/LDB (IEEE-754 single)
//   io_fpu_result[31:0] last result, held until the next completion
//   io_fpu_done        one-cycle pulse marking a new io_fpu_result
//   io_busy            high while a MUL is in flight
//
// Build option: define FPU_ROUND_NEAREST_EN for round-to-nearest-even on MUL;
// left undefined, MUL truncates toward zero and no rounding logic is built.
module fpu_seq_unit #(
    parameter int MUL_STEPS = 24
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  io_fpu_op,
    input  logic [31:0] io_fpu_ab,
    output logic [31:0] io_fpu_result,
    output logic        io_fpu_done,
    output logic        io_busy
);

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_LDA = 3'd1;
    localparam logic [2:0] OP_LDB = 3'd2;
    localparam logic [2:0] OP_MUL = 3'd3;
    localparam logic [2:0] OP_MIN = 3'd4;
    localparam logic [2:0] OP_MAX = 3'd5;
    localparam logic [2:0] OP_NEG = 3'd6;
    localparam logic [2:0] OP_ABS = 3'd7;

    localparam logic [31:0] QNAN  = 32'h7FC0_0000;
    localparam int          CNT_W = $clog2(MUL_STEPS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_UNPACK,
        S_MULT,
        S_NORM
    } state_t;

    // Operand class decided in UNPACK; NORM only uses the product for CLS_NORMAL.
    typedef enum logic [1:0] {
        CLS_NORMAL,
        CLS_ZERO,
        CLS_INF,
        CLS_NAN
    } cls_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [31:0]        r_result;
    logic               r_done;
    logic               r_sign;
    logic signed [9:0]  r_exp;
    cls_t               r_cls;
    logic [47:0]        r_acc;
    logic [47:0]        r_mcand;
    logic [23:0]        r_mplr;
    logic [CNT_W-1:0]   r_cnt;

    // ------------------------------------------------------------------
    // Wires
    // ------------------------------------------------------------------
    state_t             w_state_nxt;
    logic               w_mult_last;
    logic               w_a_lt_b;
    logic               w_any_nan;
    logic [31:0]        w_min;
    logic [31:0]        w_max;
    cls_t               w_cls;
    logic signed [9:0]  w_exp_sum;
    logic [23:0]        w_ma;
    logic [23:0]        w_mb;
    logic               w_hi;
    logic [22:0]        w_frac;
    logic signed [9:0]  w_exp_n;
    logic [22:0]        w_frac_f;
    logic signed [9:0]  w_exp_f;
    logic [31:0]        w_mul_res;

    function automatic logic f_is_nan(input logic [31:0] f);
        return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
    endfunction

    function automatic logic f_is_inf(input logic [31:0] f);
        return (f[30:23] == 8'hFF) && (f[22:0] == 23'd0);
    endfunction

    // Zero exponent covers both true zero and denormals (flush-to-zero).
    function automatic logic f_is_zero(input logic [31:0] f);
        return (f[30:23] == 8'h00);
    endfunction

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    assign w_mult_last = (r_cnt == CNT_W'(MUL_STEPS - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (io_fpu_op == OP_MUL) w_state_nxt = S_UNPACK;
            S_UNPACK: w_state_nxt = S_MULT;
            S_MULT:   if (w_mult_last) w_state_nxt = S_NORM;
            S_NORM:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // MIN / MAX: sign-magnitude ordering; differing signs make the negative
    // operand smaller, which also places -0 below +0.
    // ------------------------------------------------------------------
    always_comb begin
        w_a_lt_b = 1'b0;
        if (r_a[31] != r_b[31]) begin
            w_a_lt_b = r_a[31];
        end else if (!r_a[31]) begin
            w_a_lt_b = (r_a[30:0] < r_b[30:0]);
        end else begin
            w_a_lt_b = (r_a[30:0] > r_b[30:0]);
        end
    end

    assign w_any_nan = f_is_nan(r_a) | f_is_nan(r_b);
    assign w_min     = w_any_nan ? QNAN : (w_a_lt_b ? r_a : r_b);
    assign w_max     = w_any_nan ? QNAN : (w_a_lt_b ? r_b : r_a);

    // ------------------------------------------------------------------
    // MUL unpack: classify operands and form the biased exponent sum.
    // ------------------------------------------------------------------
    always_comb begin
        w_cls = CLS_NORMAL;
        if (w_any_nan ||
            (f_is_inf(r_a) && f_is_zero(r_b)) ||
            (f_is_zero(r_a) && f_is_inf(r_b))) begin
            w_cls = CLS_NAN;
        end else if (f_is_inf(r_a) || f_is_inf(r_b)) begin
            w_cls = CLS_INF;
        end else if (f_is_zero(r_a) || f_is_zero(r_b)) begin
            w_cls = CLS_ZERO;
        end
    end

    assign w_exp_sum = $signed({2'b00, r_a[30:23]}) + $signed({2'b00, r_b[30:23]}) - 10'sd127;
    assign w_ma      = f_is_zero(r_a) ? 24'd0 : {1'b1, r_a[22:0]};
    assign w_mb      = f_is_zero(r_b) ? 24'd0 : {1'b1, r_b[22:0]};

    // ------------------------------------------------------------------
    // MUL normalise: the 1.23 x 1.23 product lies in [1,4), so the leading
    // one is at bit 46 or bit 47.
    // ------------------------------------------------------------------
    assign w_hi    = r_acc[47];
    assign w_frac  = w_hi ? r_acc[46:24] : r_acc[45:23];
    assign w_exp_n = r_exp + (w_hi ? 10'sd1 : 10'sd0);

`ifdef FPU_ROUND_NEAREST_EN
    logic        w_guard;
    logic        w_sticky;
    logic        w_rnd_up;
    logic [24:0] w_mant_r;
    logic        w_unused_rnd;

    always_comb begin
        w_guard  = w_hi ? r_acc[23] : r_acc[22];
        w_sticky = w_hi ? (|r_acc[22:0]) : (|r_acc[21:0]);
        // Ties go to the even mantissa.
        w_rnd_up = w_guard & (w_sticky | w_frac[0]);
        w_mant_r = {2'b01, w_frac} + {24'd0, w_rnd_up};
        // On carry-out the mantissa becomes 1.0: fraction bits are already zero.
        w_frac_f = w_mant_r[22:0];
        w_exp_f  = w_exp_n + (w_mant_r[24] ? 10'sd1 : 10'sd0);
    end

    assign w_unused_rnd = w_mant_r[23];
`else
    logic w_unused_lo;

    assign w_frac_f    = w_frac;
    assign w_exp_f     = w_exp_n;
    // Truncation discards everything below the kept fraction.
    assign w_unused_lo = ^r_acc[22:0];
`endif

    always_comb begin
        w_mul_res = {r_sign, 31'd0};
        case (r_cls)
            CLS_NAN:  w_mul_res = QNAN;
            CLS_INF:  w_mul_res = {r_sign, 8'hFF, 23'd0};
            CLS_ZERO: w_mul_res = {r_sign, 31'd0};
            default: begin
                if (w_exp_f >= 10'sd255) begin
                    w_mul_res = {r_sign, 8'hFF, 23'd0};
                end else if (w_exp_f <= 10'sd0) begin
                    w_mul_res = {r_sign, 31'd0};
                end else begin
                    w_mul_res = {r_sign, w_exp_f[7:0], w_frac_f};
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_result <= 32'd0;
            r_done   <= 1'b0;
            r_sign   <= 1'b0;
            r_exp    <= 10'sd0;
            r_cls    <= CLS_NORMAL;
            r_acc    <= 48'd0;
            r_mcand  <= 48'd0;
            r_mplr   <= 24'd0;
            r_cnt    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    case (io_fpu_op)
                        OP_LDA: begin
                            r_a      <= io_fpu_ab;
                            r_result <= io_fpu_ab;
                            r_done   <= 1'b1;
                        end
                        OP_LDB: begin
                            r_b      <= io_fpu_ab;
                            r_result <= io_fpu_ab;
                            r_done   <= 1'b1;
                        end
                        OP_MIN: begin
                            r_result <= w_min;
                            r_done   <= 1'b1;
                        end
                        OP_MAX: begin
                            r_result <= w_max;
                            r_done   <= 1'b1;
                        end
                        OP_NEG: begin
                            r_result <= {~r_a[31], r_a[30:0]};
                            r_done   <= 1'b1;
                        end
                        OP_ABS: begin
                            r_result <= {1'b0, r_a[30:0]};
                            r_done   <= 1'b1;
                        end
                        default: ;  // NOP, and MUL which only moves the FSM
                    endcase
                end
                S_UNPACK: begin
                    r_sign  <= r_a[31] ^ r_b[31];
                    r_exp   <= w_exp_sum;
                    r_cls   <= w_cls;
                    r_acc   <= 48'd0;
                    r_mcand <= {24'd0, w_ma};
                    r_mplr  <= w_mb;
                    r_cnt   <= '0;
                end
                S_MULT: begin
                    // One multiplier bit per cycle, LSB first.
                    if (r_mplr[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand <= r_mcand << 1;
                    r_mplr  <= r_mplr >> 1;
                    r_cnt   <= r_cnt + CNT_W'(1);
                end
                S_NORM: begin
                    r_result <= w_mul_res;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign io_fpu_result = r_result;
    assign io_fpu_done   = r_done;
    assign io_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_fpu_seq_unit.sv
// Purpose : self-checking bench for fpu_seq_unit (directed vectors + reference model).
// Latency : model predicts done/busy/result for every cycle from the command stream.
// Backpressure: commands issued while busy are expected to be dropped.
module tb_fpu_seq_unit;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_LDA = 3'd1;
    localparam logic [2:0] OP_LDB = 3'd2;
    localparam logic [2:0] OP_MUL = 3'd3;
    localparam logic [2:0] OP_MIN = 3'd4;
    localparam logic [2:0] OP_MAX = 3'd5;
    localparam logic [2:0] OP_NEG = 3'd6;
    localparam logic [2:0] OP_ABS = 3'd7;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  io_fpu_op = 3'd0;
    logic [31:0] io_fpu_ab = 32'd0;
    logic [31:0] io_fpu_result;
    logic        io_fpu_done;
    logic        io_busy;

    int n_total = 0;
    int n_bad   = 0;

    fpu_seq_unit #(.MUL_STEPS(24)) dut (
        .clock         (clock),
        .reset         (reset),
        .io_fpu_op     (io_fpu_op),
        .io_fpu_ab     (io_fpu_ab),
        .io_fpu_result (io_fpu_result),
        .io_fpu_done   (io_fpu_done),
        .io_busy       (io_busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference arithmetic
    // ------------------------------------------------------------------
    function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b);
        logic   s;
        int     ea, eb, e;
        bit     an, bn, ai, bi, az, bz;
        longint ma, mb, p, keep, rem, half;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        an = (ea == 255) && (a[22:0] != 23'd0);
        bn = (eb == 255) && (b[22:0] != 23'd0);
        ai = (ea == 255) && (a[22:0] == 23'd0);
        bi = (eb == 255) && (b[22:0] == 23'd0);
        az = (ea == 0);
        bz = (eb == 0);
        if (an || bn || (ai && bz) || (az && bi)) return 32'h7FC00000;
        if (ai || bi) return {s, 8'hFF, 23'd0};
        if (az || bz) return {s, 31'd0};
        ma = 0; ma = {1'b1, a[22:0]};
        mb = 0; mb = {1'b1, b[22:0]};
        p  = ma * mb;
        e  = ea + eb - 127;
        if (p >= (longint'(1) << 47)) begin
            e    = e + 1;
            keep = p >> 24;
            rem  = p - (keep << 24);
            half = longint'(1) << 23;
        end else begin
            keep = p >> 23;
            rem  = p - (keep << 23);
            half = longint'(1) << 22;
        end
`ifdef FPU_ROUND_NEAREST_EN
        if ((rem > half) || ((rem == half) && (keep % 2 == 1))) keep = keep + 1;
        if (keep >= (longint'(1) << 24)) begin
            keep = keep >> 1;
            e    = e + 1;
        end
`else
        if (rem > half) keep = keep;  // truncation keeps the integer part
`endif
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0)   return {s, 31'd0};
        return {s, 8'(e), 23'(keep)};
    endfunction

    function automatic logic is_nan(input logic [31:0] f);
        return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
    endfunction

    // Total order key: -0 maps just below +0, negatives below that.
    function automatic longint order_key(input logic [31:0] f);
        longint m;
        m = 0;
        m = f[30:0];
        return f[31] ? (-m - 1) : m;
    endfunction

    function automatic logic [31:0] model_minmax(input logic [31:0] a, input logic [31:0] b,
                                                 input bit want_max);
        if (is_nan(a) || is_nan(b)) return 32'h7FC00000;
        if (want_max) return (order_key(a) > order_key(b)) ? a : b;
        return (order_key(a) < order_key(b)) ? a : b;
    endfunction

    // ------------------------------------------------------------------
    // Cycle model: m_cnt counts cycles until a pending MUL result lands.
    // ------------------------------------------------------------------
    logic [31:0] m_a = '0, m_b = '0, m_pend = '0;
    int          m_cnt = 0;
    logic        exp_done = 1'b0;
    logic        exp_busy = 1'b0;
    logic [31:0] exp_res  = '0;

    always @(posedge clock) begin
        if (reset) begin
            m_a = '0; m_b = '0; m_cnt = 0;
            exp_done = 1'b0; exp_busy = 1'b0; exp_res = '0;
        end else begin
            exp_done = 1'b0;
            if (m_cnt > 0) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    exp_res  = m_pend;
                    exp_done = 1'b1;
                end
            end else begin
                case (io_fpu_op)
                    OP_LDA: begin m_a = io_fpu_ab; exp_res = io_fpu_ab; exp_done = 1'b1; end
                    OP_LDB: begin m_b = io_fpu_ab; exp_res = io_fpu_ab; exp_done = 1'b1; end
                    OP_MUL: begin m_pend = model_mul(m_a, m_b); m_cnt = 26; end
                    OP_MIN: begin exp_res = model_minmax(m_a, m_b, 1'b0); exp_done = 1'b1; end
                    OP_MAX: begin exp_res = model_minmax(m_a, m_b, 1'b1); exp_done = 1'b1; end
                    OP_NEG: begin exp_res = m_a ^ 32'h80000000; exp_done = 1'b1; end
                    OP_ABS: begin exp_res = m_a & 32'h7FFFFFFF; exp_done = 1'b1; end
                    default: ;
                endcase
            end
            exp_busy = (m_cnt > 0);
        end
    end

    always @(negedge clock) begin
        check("cyc_done", {31'd0, io_fpu_done}, {31'd0, exp_done});
        check("cyc_busy", {31'd0, io_busy}, {31'd0, exp_busy});
        check("cyc_result", io_fpu_result, exp_res);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change on the falling edge)
    // ------------------------------------------------------------------
    task automatic op1(input logic [2:0] op, input logic [31:0] ab);
        io_fpu_op = op;
        io_fpu_ab = ab;
        @(negedge clock);
        io_fpu_op = OP_NOP;
    endtask

    task automatic single(input string name, input logic [2:0] op, input logic [31:0] ab,
                          input logic [31:0] lit);
        op1(op, ab);
        check({name, "_done"}, {31'd0, io_fpu_done}, 32'd1);
        check(name, io_fpu_result, lit);
    endtask

    // Waits for done starting at cycle t+k0; counts busy cycles on the way.
    task automatic wait_mul(input string name, input int k0, input logic [31:0] lit,
                            output int busy_n);
        int k;
        k = k0;
        busy_n = 0;
        while (io_fpu_done !== 1'b1 && k < 40) begin
            if (io_busy === 1'b1) busy_n++;
            @(negedge clock);
            k++;
        end
        check({name, "_lat"}, 32'(k), 32'd27);
        check(name, io_fpu_result, lit);
    endtask

    task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] lit);
        int busy_n;
        op1(OP_LDA, a);
        op1(OP_LDB, b);
        op1(OP_MUL, 32'd0);
        wait_mul(name, 1, lit, busy_n);
        check({name, "_busycyc"}, 32'(busy_n), 32'd26);
    endtask

    typedef struct { logic [31:0] a; logic [31:0] b; } pair_t;
    pair_t extra[7] = '{
        '{32'h3F8CCCCD, 32'h3F8CCCCD},
        '{32'hC0490FDB, 32'h3EA2F983},
        '{32'h00800000, 32'h00800000},
        '{32'hBF800000, 32'h7F800000},
        '{32'h3FFFFFFF, 32'h3FFFFFFF},
        '{32'h7F7FFFFF, 32'h3F800001},
        '{32'h80000000, 32'h3F800000}
    };

    initial begin
        int busy_n;
        int dones;
        logic [31:0] rnd_lit;

        repeat (3) @(negedge clock);
        check("rst_result", io_fpu_result, 32'h00000000);
        check("rst_done", {31'd0, io_fpu_done}, 32'd0);
        check("rst_busy", {31'd0, io_busy}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        run_mul("mul_2x3", 32'h40000000, 32'h40400000, 32'h40C00000);
        run_mul("mul_ovf", 32'h7F000000, 32'h7F000000, 32'h7F800000);
        run_mul("mul_inf0", 32'h7F800000, 32'h00000000, 32'h7FC00000);
        run_mul("mul_denorm", 32'h00000001, 32'h3F800000, 32'h00000000);
`ifdef FPU_ROUND_NEAREST_EN
        rnd_lit = 32'h3FC00002;
`else
        rnd_lit = 32'h3FC00001;
`endif
        run_mul("mul_round", 32'h3F800001, 32'h3FC00000, rnd_lit);

        // Back-to-back single-cycle ops, one per cycle.
        io_fpu_op = OP_LDA; io_fpu_ab = 32'h80000000; @(negedge clock);
        io_fpu_op = OP_LDB; io_fpu_ab = 32'h00000000; @(negedge clock);
        io_fpu_op = OP_MIN; @(negedge clock);
        check("min_negzero", io_fpu_result, 32'h80000000);
        io_fpu_op = OP_MAX; @(negedge clock);
        check("max_negzero", io_fpu_result, 32'h00000000);
        io_fpu_op = OP_NEG; @(negedge clock);
        io_fpu_op = OP_ABS; @(negedge clock);
        io_fpu_op = OP_NOP; @(negedge clock);

        single("lda_nan", OP_LDA, 32'h7FC00001, 32'h7FC00001);
        single("max_nan", OP_MAX, 32'd0, 32'h7FC00000);
        single("min_nan", OP_MIN, 32'd0, 32'h7FC00000);
        single("lda_one", OP_LDA, 32'h3F800000, 32'h3F800000);
        single("neg_one", OP_NEG, 32'd0, 32'hBF800000);
        single("neg_keepsA", OP_NEG, 32'd0, 32'hBF800000);
        single("lda_m2", OP_LDA, 32'hC0000000, 32'hC0000000);
        single("abs_m2", OP_ABS, 32'd0, 32'h40000000);
        single("ldb_m3", OP_LDB, 32'hC0400000, 32'hC0400000);
        single("min_neg", OP_MIN, 32'd0, 32'hC0400000);
        single("max_neg", OP_MAX, 32'd0, 32'hC0000000);

        foreach (extra[i]) begin
            op1(OP_LDA, extra[i].a);
            op1(OP_LDB, extra[i].b);
            op1(OP_MUL, 32'd0);
            repeat (28) @(negedge clock);
        end

        // Command during MUL is dropped; A must stay intact.
        op1(OP_LDA, 32'h40000000);
        op1(OP_LDB, 32'h40400000);
        op1(OP_MUL, 32'd0);
        repeat (4) @(negedge clock);
        op1(OP_LDA, 32'h12345678);
        wait_mul("mul_drop", 6, 32'h40C00000, busy_n);
        @(negedge clock);
        single("neg_after_drop", OP_NEG, 32'd0, 32'hC0000000);

        // Reset in the middle of a MUL.
        op1(OP_MUL, 32'd0);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_result", io_fpu_result, 32'h00000000);
        check("abort_busy", {31'd0, io_busy}, 32'd0);
        check("abort_done", {31'd0, io_fpu_done}, 32'd0);
        dones = 0;
        repeat (30) begin
            @(negedge clock);
            if (io_fpu_done === 1'b1) dones++;
        end
        check("abort_nodone", 32'(dones), 32'd0);
        single("neg_after_rst", OP_NEG, 32'd0, 32'h80000000);

        repeat (2) @(negedge clock);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
